// File: rtl/serial_frame_packer.sv
// Serial frame receiver (start, 8 data bits MSB first, stop) feeding a small holding FIFO
// that drains into a downstream FIFO. Even parity is compiled in with `define FRAME_PARITY_EN.
module serial_frame_packer #(
    parameter int HOLD_DEPTH = 2
) (
    input  logic       myclock,
    input  logic       resetn,
    input  logic       sin,
    input  logic       fifo_full,
    input  logic       clr_err,
    output logic       push,
    output logic [7:0] wdata,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun,
    output logic [1:0] state_dbg
);

    localparam int PW = (HOLD_DEPTH > 1) ? $clog2(HOLD_DEPTH) : 1;
    localparam int CW = $clog2(HOLD_DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      mem_q [HOLD_DEPTH];
    logic [7:0]      mem_d [HOLD_DEPTH];
    logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic            frame_err_q, frame_err_d;
    logic            overrun_q, overrun_d;
`ifdef FRAME_PARITY_EN
    logic            par_bad_q, par_bad_d;
`endif

    logic byte_good, set_ferr, enq, deq, full, drop;

    // State register
    always_ff @(posedge myclock or negedge resetn) begin
        if (!resetn) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (!sin) state_d = S_DATA;
            S_DATA: begin
                if (cnt_q == 3'd7) begin
`ifdef FRAME_PARITY_EN
                    state_d = S_PARITY;
`else
                    state_d = S_STOP;
`endif
                end
            end
            S_STOP:  state_d = S_IDLE;
            default: state_d = S_STOP;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy      = (state_q != S_IDLE);
        state_dbg = state_q;
    end

    // Bit counter, shifter and frame validation
    always_comb begin
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        byte_good = 1'b0;
        set_ferr  = 1'b0;
`ifdef FRAME_PARITY_EN
        par_bad_d = par_bad_q;
`endif
        case (state_q)
            S_IDLE: cnt_d = 3'd0;
            S_DATA: begin
                shift_d = {shift_q[6:0], sin};
                cnt_d   = cnt_q + 3'd1;
            end
`ifdef FRAME_PARITY_EN
            S_PARITY: begin
                par_bad_d = (sin != ^shift_q);
                set_ferr  = (sin != ^shift_q);
            end
            S_STOP: begin
                if (sin) byte_good = !par_bad_q;
                else     set_ferr  = 1'b1;
            end
`else
            S_STOP: begin
                if (sin) byte_good = 1'b1;
                else     set_ferr  = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // Holding buffer: a full buffer still accepts a byte when the head leaves on the same edge
    always_comb begin
        deq     = push;
        full    = (count_q == CW'(HOLD_DEPTH));
        enq     = byte_good && (!full || deq);
        drop    = byte_good && full && !deq;
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (enq) begin
            mem_d[tail_q] = shift_q;
            tail_d = (tail_q == PW'(HOLD_DEPTH - 1)) ? '0 : tail_q + PW'(1);
        end
        if (deq) begin
            head_d = (head_q == PW'(HOLD_DEPTH - 1)) ? '0 : head_q + PW'(1);
        end
        case ({enq, deq})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // A new error on the clearing edge wins
        frame_err_d = (frame_err_q & ~clr_err) | set_ferr;
        overrun_d   = (overrun_q & ~clr_err) | drop;
    end

    always_ff @(posedge myclock or negedge resetn) begin
        if (!resetn) begin
            cnt_q       <= 3'd0;
            shift_q     <= 8'h00;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            for (int i = 0; i < HOLD_DEPTH; i++) mem_q[i] <= 8'h00;
`ifdef FRAME_PARITY_EN
            par_bad_q   <= 1'b0;
`endif
        end else begin
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            mem_q       <= mem_d;
`ifdef FRAME_PARITY_EN
            par_bad_q   <= par_bad_d;
`endif
        end
    end

    assign push      = (count_q != '0) && !fifo_full;
    assign wdata     = (count_q != '0) ? mem_q[head_q] : 8'h00;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_serial_frame_packer.sv
// Directed bench for serial_frame_packer: a push monitor compares each written byte
// against a queue of expected bytes filled as frames are sent.
module tb_serial_frame_packer;

    logic       myclock = 1'b0;
    logic       resetn  = 1'b1;
    logic       sin     = 1'b1;
    logic       fifo_full = 1'b0;
    logic       clr_err = 1'b0;
    logic       push;
    logic [7:0] wdata;
    logic       busy;
    logic       frame_err;
    logic       overrun;
    logic [1:0] state_dbg;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] exp_q[$];
    int         push_cyc[$];

    serial_frame_packer #(.HOLD_DEPTH(2)) dut (
        .myclock  (myclock),
        .resetn   (resetn),
        .sin      (sin),
        .fifo_full(fifo_full),
        .clr_err  (clr_err),
        .push     (push),
        .wdata    (wdata),
        .busy     (busy),
        .frame_err(frame_err),
        .overrun  (overrun),
        .state_dbg(state_dbg)
    );

    // Clock and cycle counter
    always #5 myclock = ~myclock;
    always @(posedge myclock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every push must match the oldest expected byte
    always @(negedge myclock) begin
        if (resetn && push) begin
            push_cyc.push_back(cyc);
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_push observed=%0h expected=none", wdata);
            end
            if (exp_q.size() != 0) begin
                logic [7:0] e;
                e = exp_q.pop_front();
                checks++;
                assert (wdata === e) else begin
                    errors++;
                    $error("FAIL push_data observed=%0h expected=%0h", wdata, e);
                end
            end
        end
    end

    task automatic send_bit(input logic b);
        sin = b;
        @(posedge myclock);
        #1;
    endtask

    task automatic idle(input int n);
        sin = 1'b1;
        repeat (n) begin
            @(posedge myclock);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b);
        send_bit(1'b0);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        send_bit(stop_b);
        sin = 1'b1;
    endtask

`ifdef FRAME_PARITY_EN
    task automatic send_par_frame(input logic [7:0] d, input logic par_b);
        send_bit(1'b0);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        send_bit(par_b);
        send_bit(1'b1);
        sin = 1'b1;
    endtask
`endif

    initial begin
        // Reset: outputs must be forced low asynchronously
        #3 resetn = 1'b0;
        #1;
        chk("rst_push", {31'd0, push}, 32'd0);
        chk("rst_wdata", {24'd0, wdata}, 32'h00);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);
        @(negedge myclock);
        @(negedge myclock);
        resetn = 1'b1;
        @(posedge myclock);
        #1;
        idle(2);

        // Single good frame
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        idle(3);
        chk("a5_frame_err", {31'd0, frame_err}, 32'd0);
        chk("a5_drained", exp_q.size(), 32'd0);

        // Bad stop bit, then clear
        send_frame(8'h3C, 1'b0);
        chk("badstop_frame_err", {31'd0, frame_err}, 32'd1);
        chk("badstop_busy", {31'd0, busy}, 32'd0);
        clr_err = 1'b1;
        idle(1);
        clr_err = 1'b0;
        chk("clr_frame_err", {31'd0, frame_err}, 32'd0);
        idle(2);

        // Overrun with downstream full
        fifo_full = 1'b1;
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        send_frame(8'h33, 1'b1);
        idle(1);
        chk("ovr_overrun", {31'd0, overrun}, 32'd1);
        chk("ovr_push_blocked", {31'd0, push}, 32'd0);
        push_cyc.delete();
        fifo_full = 1'b0;
        idle(4);
        chk("ovr_push_count", push_cyc.size(), 32'd2);
        if (push_cyc.size() == 2)
            chk("ovr_consecutive", push_cyc[1] - push_cyc[0], 32'd1);
        chk("ovr_drained", exp_q.size(), 32'd0);
        clr_err = 1'b1;
        idle(1);
        clr_err = 1'b0;
        chk("clr_overrun", {31'd0, overrun}, 32'd0);

        // Back-to-back frames
        push_cyc.delete();
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h00);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h00, 1'b1);
        idle(3);
        chk("b2b_push_count", push_cyc.size(), 32'd2);
        if (push_cyc.size() == 2)
            chk("b2b_spacing", push_cyc[1] - push_cyc[0], 32'd10);
        chk("b2b_frame_err", {31'd0, frame_err}, 32'd0);

        // Reset during the 4th data bit abandons the partial byte
        push_cyc.delete();
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        sin = 1'b1;
        #2 resetn = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        @(negedge myclock);
        resetn = 1'b1;
        @(posedge myclock);
        #1;
        idle(2);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        idle(3);
        chk("midrst_push_count", push_cyc.size(), 32'd1);

`ifdef FRAME_PARITY_EN
        // Even parity: bad parity bit discards, good one delivers
        push_cyc.delete();
        send_par_frame(8'h03, 1'b1);
        chk("par_bad_frame_err", {31'd0, frame_err}, 32'd1);
        clr_err = 1'b1;
        idle(1);
        clr_err = 1'b0;
        exp_q.push_back(8'h03);
        send_par_frame(8'h03, 1'b0);
        idle(3);
        chk("par_good_frame_err", {31'd0, frame_err}, 32'd0);
        chk("par_push_count", push_cyc.size(), 32'd1);
`endif

        chk("final_queue_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
